// File: rtl/imem_loader.sv
// Framed byte-stream loader for the instruction memory. It forwards the payload, then issues the start pulse.
// Build option: define IMEM_LOADER_CHECKSUM_EN to add the trailing XOR checksum byte and the CHK state.
//
// state   | meaning
// IDLE    | hunting for SYNC_BYTE; other bytes are dropped
// LEN_HI  | capturing length[15:8]
// LEN_LO  | capturing length[7:0] and range-checking the full length
// DATA    | forwarding payload bytes to the instruction memory
// CHK     | comparing the trailing checksum byte (checksum build only)
// START   | one-cycle execution start pulse
// RUN     | load finished; the host channel is ignored until reset
// ERR     | frame rejected; the host channel is ignored until reset
module imem_loader #(
    parameter int          MAX_BYTES = 1000,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic        SYS_clk,
    input  logic        SYS_reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        PC_data_valid,
    output logic [7:0]  PC_data,
    output logic        SYS_start_button,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] bytes_loaded
);

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_START, S_RUN, S_ERR, S_CHK
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_START, S_RUN, S_ERR
    } state_t;
`endif

    localparam logic [16:0] MAX_LEN = 17'(MAX_BYTES);

    state_t      state;
    logic [7:0]  len_hi;
    logic [15:0] remain;
    logic [7:0]  chk_acc;
    logic        accept;

    assign accept = rx_valid && rx_ready;

    // rx_ready drops on the same edge that enters START/RUN/ERR, so the byte taken on that edge is kept.
    always_ff @(posedge SYS_clk) begin
        if (SYS_reset) begin
            state            <= S_IDLE;
            rx_ready         <= 1'b1;
            PC_data_valid    <= 1'b0;
            PC_data          <= 8'h00;
            SYS_start_button <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            error            <= 1'b0;
            bytes_loaded     <= 16'd0;
            len_hi           <= 8'h00;
            remain           <= 16'd0;
            chk_acc          <= 8'h00;
        end else begin
            PC_data_valid    <= 1'b0;
            SYS_start_button <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept && rx_data == SYNC_BYTE) begin
                        state        <= S_LEN_HI;
                        busy         <= 1'b1;
                        chk_acc      <= 8'h00;
                        bytes_loaded <= 16'd0;
                    end
                end
                S_LEN_HI: begin
                    if (accept) begin
                        len_hi <= rx_data;
                        state  <= S_LEN_LO;
                    end
                end
                S_LEN_LO: begin
                    if (accept) begin
                        if ({1'b0, len_hi, rx_data} > MAX_LEN) begin
                            state    <= S_ERR;
                            rx_ready <= 1'b0;
                            busy     <= 1'b0;
                            error    <= 1'b1;
                        end else if ({len_hi, rx_data} == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            state <= S_CHK;
`else
                            state            <= S_START;
                            SYS_start_button <= 1'b1;
                            rx_ready         <= 1'b0;
`endif
                        end else begin
                            remain <= {len_hi, rx_data};
                            state  <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        PC_data       <= rx_data;
                        PC_data_valid <= 1'b1;
                        chk_acc       <= chk_acc ^ rx_data;
                        bytes_loaded  <= bytes_loaded + 16'd1;
                        remain        <= remain - 16'd1;
                        // remain counts down to the terminal byte of the payload
                        if (remain == 16'd1) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            state <= S_CHK;
`else
                            state            <= S_START;
                            SYS_start_button <= 1'b1;
                            rx_ready         <= 1'b0;
`endif
                        end
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                S_CHK: begin
                    if (accept) begin
                        rx_ready <= 1'b0;
                        if (rx_data == chk_acc) begin
                            state            <= S_START;
                            SYS_start_button <= 1'b1;
                        end else begin
                            state <= S_ERR;
                            busy  <= 1'b0;
                            error <= 1'b1;
                        end
                    end
                end
`endif
                S_START: begin
                    state <= S_RUN;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                S_RUN: begin
                end
                S_ERR: begin
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed, table-driven bench for imem_loader. Each frame carries its checksum byte.
// In the default build the loader ignores that byte because it is already in RUN when the byte arrives.
module tb_imem_loader;

    logic        SYS_clk = 1'b0;
    logic        SYS_reset = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_ready;
    logic        PC_data_valid;
    logic [7:0]  PC_data;
    logic        SYS_start_button;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] bytes_loaded;

    imem_loader dut (
        .SYS_clk          (SYS_clk),
        .SYS_reset        (SYS_reset),
        .rx_valid         (rx_valid),
        .rx_data          (rx_data),
        .rx_ready         (rx_ready),
        .PC_data_valid    (PC_data_valid),
        .PC_data          (PC_data),
        .SYS_start_button (SYS_start_button),
        .busy             (busy),
        .done             (done),
        .error            (error),
        .bytes_loaded     (bytes_loaded)
    );

    always #5 SYS_clk = ~SYS_clk;

    int cyc = 0;
    always @(posedge SYS_clk) cyc <= cyc + 1;

    int         errors = 0;
    int         checks = 0;
    int         n_wr = 0;
    int         n_start = 0;
    int         start_cyc = -1;
    logic [7:0] wr_data [16];
    int         wr_cyc  [16];

    always @(negedge SYS_clk) begin
        if (PC_data_valid) begin
            if (n_wr < 16) begin
                wr_data[n_wr] = PC_data;
                wr_cyc[n_wr]  = cyc;
            end
            n_wr = n_wr + 1;
        end
        if (SYS_start_button) begin
            n_start   = n_start + 1;
            start_cyc = cyc;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic clear_mon();
        n_wr      = 0;
        n_start   = 0;
        start_cyc = -1;
    endtask

    task automatic do_reset();
        SYS_reset = 1'b1;
        rx_valid  = 1'b0;
        repeat (2) @(posedge SYS_clk);
        #1;
        SYS_reset = 1'b0;
        clear_mon();
    endtask

    // presents one byte across one rising edge; returns the cycle number of that edge
    task automatic send(input logic [7:0] b, output int edge_cyc);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge SYS_clk);
        #1;
        edge_cyc = cyc;
    endtask

    task automatic idle(input int n);
        rx_valid = 1'b0;
        repeat (n) begin
            @(posedge SYS_clk);
        end
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, ".rx_ready"},      int'(rx_ready), 1);
        chk({tag, ".PC_data_valid"}, int'(PC_data_valid), 0);
        chk({tag, ".PC_data"},       int'(PC_data), 0);
        chk({tag, ".start"},         int'(SYS_start_button), 0);
        chk({tag, ".busy"},          int'(busy), 0);
        chk({tag, ".done"},          int'(done), 0);
        chk({tag, ".error"},         int'(error), 0);
        chk({tag, ".bytes_loaded"},  int'(bytes_loaded), 0);
    endtask

    typedef struct {
        string      name;
        int         n;
        logic [7:0] b [10];
        int         exp_wr;
        logic [7:0] w [4];
        bit         exp_done;
        bit         exp_err;
        int         exp_bl;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int t, t0, t_last;
        logic [7:0] x;

        vecs[0] = '{"frame4",  8, '{8'hA5,8'h00,8'h04,8'h13,8'h00,8'h00,8'h00,8'h13,8'h00,8'h00},
                    4, '{8'h13,8'h00,8'h00,8'h00}, 1'b1, 1'b0, 4};
`ifdef IMEM_LOADER_CHECKSUM_EN
        vecs[1] = '{"badchk",  8, '{8'hA5,8'h00,8'h04,8'h13,8'h00,8'h00,8'h00,8'h12,8'h00,8'h00},
                    4, '{8'h13,8'h00,8'h00,8'h00}, 1'b0, 1'b1, 4};
`else
        vecs[1] = '{"badchk",  8, '{8'hA5,8'h00,8'h04,8'h13,8'h00,8'h00,8'h00,8'h12,8'h00,8'h00},
                    4, '{8'h13,8'h00,8'h00,8'h00}, 1'b1, 1'b0, 4};
`endif
        vecs[2] = '{"garbage", 8, '{8'h00,8'hFF,8'h5A,8'hA5,8'h00,8'h01,8'hAA,8'hAA,8'h00,8'h00},
                    1, '{8'hAA,8'h00,8'h00,8'h00}, 1'b1, 1'b0, 1};
        vecs[3] = '{"toolong", 5, '{8'hA5,8'h03,8'hE9,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00},
                    0, '{8'h00,8'h00,8'h00,8'h00}, 1'b0, 1'b1, 0};
        vecs[4] = '{"zerolen", 4, '{8'hA5,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00},
                    0, '{8'h00,8'h00,8'h00,8'h00}, 1'b1, 1'b0, 0};
        vecs[5] = '{"trail",   7, '{8'hA5,8'h00,8'h02,8'h11,8'h22,8'h33,8'h44,8'h00,8'h00,8'h00},
                    2, '{8'h11,8'h22,8'h00,8'h00}, 1'b1, 1'b0, 2};

        SYS_reset = 1'b1;
        repeat (3) @(posedge SYS_clk);
        #1;
        check_reset_outputs("reset");
        SYS_reset = 1'b0;

        for (int v = 0; v < 6; v++) begin
            do_reset();
            for (int i = 0; i < vecs[v].n; i++) send(vecs[v].b[i], t);
            idle(4);
            chk({vecs[v].name, ".writes"}, n_wr, vecs[v].exp_wr);
            for (int i = 0; i < vecs[v].exp_wr; i++)
                chk($sformatf("%s.wr%0d", vecs[v].name, i), int'(wr_data[i]), int'(vecs[v].w[i]));
            chk({vecs[v].name, ".starts"},   n_start, vecs[v].exp_done ? 1 : 0);
            chk({vecs[v].name, ".done"},     int'(done), int'(vecs[v].exp_done));
            chk({vecs[v].name, ".error"},    int'(error), int'(vecs[v].exp_err));
            chk({vecs[v].name, ".busy"},     int'(busy), 0);
            chk({vecs[v].name, ".rx_ready"}, int'(rx_ready), 0);
            chk({vecs[v].name, ".bytes"},    int'(bytes_loaded), vecs[v].exp_bl);
        end

        // latency: back-to-back writes, start one cycle after the final frame byte, done after start
        do_reset();
        send(8'hA5, t0);
        send(8'h00, t);
        send(8'h04, t);
        send(8'h13, t);
        send(8'h00, t);
        send(8'h00, t);
        send(8'h00, t_last);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send(8'h13, t_last);
`endif
        chk("lat.busy_in_start", int'(busy), 1);
        chk("lat.rx_ready_in_start", int'(rx_ready), 0);
        chk("lat.start_now", int'(SYS_start_button), 1);
        chk("lat.done_not_yet", int'(done), 0);
        idle(1);
        chk("lat.done_after_start", int'(done), 1);
        chk("lat.start_cleared", int'(SYS_start_button), 0);
        idle(2);
        for (int i = 0; i < 4; i++)
            chk($sformatf("lat.wr_cyc%0d", i), wr_cyc[i], t0 + 3 + i);
        chk("lat.start_cyc", start_cyc, t_last);

        // reset in the middle of the payload, then a clean frame
        do_reset();
        send(8'hA5, t);
        send(8'h00, t);
        send(8'h04, t);
        send(8'h11, t);
        send(8'h22, t);
        chk("midrst.busy_before", int'(busy), 1);
        SYS_reset = 1'b1;
        rx_data   = 8'h33;
        @(posedge SYS_clk);
        #1;
        check_reset_outputs("midrst");
        idle(2);
        chk("midrst.writes_before", n_wr, 2);
        SYS_reset = 1'b0;
        clear_mon();
        for (int i = 0; i < vecs[0].n; i++) send(vecs[0].b[i], t);
        idle(3);
        chk("midrst.reload_writes", n_wr, 4);
        chk("midrst.reload_wr0", int'(wr_data[0]), 8'h13);
        chk("midrst.reload_done", int'(done), 1);
        chk("midrst.reload_bytes", int'(bytes_loaded), 4);

        // largest legal frame: exactly MAX_BYTES payload bytes
        do_reset();
        send(8'hA5, t);
        send(8'h03, t);
        send(8'hE8, t);
        x = 8'h00;
        for (int i = 0; i < 1000; i++) begin
            send(8'(i), t);
            x = x ^ 8'(i);
        end
        send(x, t);
        idle(3);
        chk("max.writes", n_wr, 1000);
        chk("max.bytes", int'(bytes_loaded), 1000);
        chk("max.done", int'(done), 1);
        chk("max.error", int'(error), 0);
        chk("max.starts", n_start, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
